// File: rtl/scr1_tcm_arb_pkg.sv
// Shared types for the TCM data-port arbiter:
// memory command/width/response enums and the owner ID.
package scr1_tcm_arb_pkg;

   localparam int SCR1_DMEM_AWIDTH = 32;
   localparam int SCR1_DMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   typedef enum logic {
      SCR1_TCM_ARB_CORE = 1'b0,
      SCR1_TCM_ARB_DMA  = 1'b1
   } type_scr1_tcm_arb_id_e;

endpackage

// File: rtl/scr1_tcm_dmem_arb_if.sv
// Data-memory request/response channel.
// master drives the request, slave returns ack and response.
interface scr1_tcm_dmem_arb_if;
   import scr1_tcm_arb_pkg::*;

   logic                          req;
   type_scr1_mem_cmd_e            cmd;
   type_scr1_mem_width_e          width;
   logic [SCR1_DMEM_AWIDTH-1:0]   addr;
   logic [SCR1_DMEM_DWIDTH-1:0]   wdata;
   logic                          req_ack;
   logic [SCR1_DMEM_DWIDTH-1:0]   rdata;
   type_scr1_mem_resp_e           resp;

   modport master (
      output req, cmd, width, addr, wdata,
      input  req_ack, rdata, resp
   );

   modport slave (
      input  req, cmd, width, addr, wdata,
      output req_ack, rdata, resp
   );

endinterface

// File: rtl/scr1_tcm_arb_idq.sv
// In-order FIFO of 1-bit owner IDs for transactions
// accepted by the TCM and still awaiting a response.
module scr1_tcm_arb_idq
   import scr1_tcm_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  type_scr1_tcm_arb_id_e id_in,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output type_scr1_tcm_arb_id_e head
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   type_scr1_tcm_arb_id_e mem [DEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [CW-1:0]         cnt;
   logic                  pop_ok;
   logic                  push_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign head    = mem[rptr];
   assign pop_ok  = pop & ~empty;
   // a same-cycle pop frees the slot being written
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= SCR1_TCM_ARB_CORE;
         end
      end else begin
         if (push_ok) begin
            mem[wptr] <= id_in;
            wptr      <= ptr_inc(wptr);
         end
         if (pop_ok) begin
            rptr <= ptr_inc(rptr);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/scr1_tcm_dmem_arb.sv
// Two-master arbiter in front of the TCM data port:
// zero-latency request mux, in-order response routing.
module scr1_tcm_dmem_arb
   import scr1_tcm_arb_pkg::*;
#(
   parameter int OUTST_DEPTH     = 2,
   parameter bit CORE_PRIO_FIXED = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   scr1_tcm_dmem_arb_if.slave  core,
   scr1_tcm_dmem_arb_if.slave  dma,
   scr1_tcm_dmem_arb_if.master tcm,
   output logic                arb_err
);

   type_scr1_tcm_arb_id_e sel;
   type_scr1_tcm_arb_id_e rr_next;
   type_scr1_tcm_arb_id_e head;
   logic                  both;
   logic                  acc;
   logic                  rsp_vld;
   logic                  pop;
   logic                  q_full;
   logic                  q_empty;
   logic                  q_full_eff;
   logic                  to_core;
   logic                  to_dma;

   assign both = core.req & dma.req;

   always_comb begin
      sel = SCR1_TCM_ARB_CORE;
      unique case (1'b1)
         core.req & ~dma.req:     sel = SCR1_TCM_ARB_CORE;
         dma.req & ~core.req:     sel = SCR1_TCM_ARB_DMA;
         both & CORE_PRIO_FIXED:  sel = SCR1_TCM_ARB_CORE;
         both & ~CORE_PRIO_FIXED: sel = rr_next;
         default:                 sel = SCR1_TCM_ARB_CORE;
      endcase
   end

   assign rsp_vld    = (tcm.resp != SCR1_MEM_RESP_NOTRDY);
   assign pop        = rsp_vld & ~q_empty;
   assign q_full_eff = q_full & ~pop;

   assign tcm.req   = (core.req | dma.req) & ~q_full_eff;
   assign tcm.cmd   = (sel == SCR1_TCM_ARB_DMA) ? dma.cmd   : core.cmd;
   assign tcm.width = (sel == SCR1_TCM_ARB_DMA) ? dma.width : core.width;
   assign tcm.addr  = (sel == SCR1_TCM_ARB_DMA) ? dma.addr  : core.addr;
   assign tcm.wdata = (sel == SCR1_TCM_ARB_DMA) ? dma.wdata : core.wdata;

   assign acc          = tcm.req & tcm.req_ack;
   assign core.req_ack = acc & (sel == SCR1_TCM_ARB_CORE);
   assign dma.req_ack  = acc & (sel == SCR1_TCM_ARB_DMA);

   // an empty queue means nobody owns the response: drop it
   assign to_core = pop & (head == SCR1_TCM_ARB_CORE);
   assign to_dma  = pop & (head == SCR1_TCM_ARB_DMA);

   assign core.resp  = to_core ? tcm.resp  : SCR1_MEM_RESP_NOTRDY;
   assign core.rdata = to_core ? tcm.rdata : '0;
   assign dma.resp   = to_dma  ? tcm.resp  : SCR1_MEM_RESP_NOTRDY;
   assign dma.rdata  = to_dma  ? tcm.rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_next <= SCR1_TCM_ARB_CORE;
         arb_err <= 1'b0;
      end else begin
         if (acc & both) begin
            rr_next <= (sel == SCR1_TCM_ARB_CORE) ?
                       SCR1_TCM_ARB_DMA : SCR1_TCM_ARB_CORE;
         end
         arb_err <= rsp_vld & q_empty;
      end
   end

   scr1_tcm_arb_idq #(
      .DEPTH (OUTST_DEPTH)
   ) i_idq (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (acc),
      .id_in (sel),
      .pop   (pop),
      .full  (q_full),
      .empty (q_empty),
      .head  (head)
   );

endmodule

// File: tb/tb_scr1_tcm_dmem_arb.sv
// Bench for scr1_tcm_dmem_arb: round-robin and fixed-priority
// instances share stimulus; a queue holds expected responses.
module tb_scr1_tcm_dmem_arb;
   import scr1_tcm_arb_pkg::*;

   typedef struct {
      type_scr1_tcm_arb_id_e own;
      logic [31:0]           data;
      type_scr1_mem_resp_e   rsp;
   } sb_t;

   logic clk;
   logic rst_n;
   logic err0;
   logic err1;
   bit   use1;
   bit   err_pend;
   int   n_cmp;
   int   n_err;
   sb_t  sbq[$];

   logic [31:0]        caddr;
   logic [31:0]        daddr;
   type_scr1_mem_cmd_e dcmd;

   scr1_tcm_dmem_arb_if c0 ();
   scr1_tcm_dmem_arb_if d0 ();
   scr1_tcm_dmem_arb_if t0 ();
   scr1_tcm_dmem_arb_if c1 ();
   scr1_tcm_dmem_arb_if d1 ();
   scr1_tcm_dmem_arb_if t1 ();

   assign c1.req     = c0.req;
   assign c1.cmd     = c0.cmd;
   assign c1.width   = c0.width;
   assign c1.addr    = c0.addr;
   assign c1.wdata   = c0.wdata;
   assign d1.req     = d0.req;
   assign d1.cmd     = d0.cmd;
   assign d1.width   = d0.width;
   assign d1.addr    = d0.addr;
   assign d1.wdata   = d0.wdata;
   assign t1.req_ack = t0.req_ack;
   assign t1.rdata   = t0.rdata;
   assign t1.resp    = t0.resp;

   scr1_tcm_dmem_arb #(
      .OUTST_DEPTH     (2),
      .CORE_PRIO_FIXED (1'b0)
   ) u_dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .core    (c0),
      .dma     (d0),
      .tcm     (t0),
      .arb_err (err0)
   );

   scr1_tcm_dmem_arb #(
      .OUTST_DEPTH     (2),
      .CORE_PRIO_FIXED (1'b1)
   ) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .core    (c1),
      .dma     (d1),
      .tcm     (t1),
      .arb_err (err1)
   );

   logic                c_ack, d_ack, t_req, a_err;
   logic [31:0]         c_rd, d_rd, t_addr;
   type_scr1_mem_resp_e c_rsp, d_rsp;
   type_scr1_mem_cmd_e  t_cmd;

   assign c_ack  = use1 ? c1.req_ack : c0.req_ack;
   assign d_ack  = use1 ? d1.req_ack : d0.req_ack;
   assign t_req  = use1 ? t1.req     : t0.req;
   assign a_err  = use1 ? err1       : err0;
   assign c_rd   = use1 ? c1.rdata   : c0.rdata;
   assign d_rd   = use1 ? d1.rdata   : d0.rdata;
   assign t_addr = use1 ? t1.addr    : t0.addr;
   assign c_rsp  = use1 ? c1.resp    : c0.resp;
   assign d_rsp  = use1 ? d1.resp    : d0.resp;
   assign t_cmd  = use1 ? t1.cmd     : t0.cmd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] tcm_mem(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEAD_BEEF : (~a ^ 32'h5A5A_0000);
   endfunction

   task automatic idle();
      c0.req = 1'b0;
      d0.req = 1'b0;
      t0.req_ack = 1'b0;
      t0.resp = SCR1_MEM_RESP_NOTRDY;
      t0.rdata = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      idle();
      sbq.delete();
      err_pend = 1'b0;
      @(negedge clk);
      check("rst_core_resp", c_rsp, SCR1_MEM_RESP_NOTRDY);
      check("rst_dma_resp", d_rsp, SCR1_MEM_RESP_NOTRDY);
      check("rst_core_rdata", c_rd, 32'h0);
      check("rst_dma_rdata", d_rd, 32'h0);
      check("rst_arb_err", a_err, 1'b0);
      check("rst_tcm_req", t_req, 1'b0);
      #2;
      rst_n = 1'b1;
   endtask

   // exp: 0 core grant, 1 dma grant, -1 no grant
   task automatic cyc(input bit cr, input bit dr, input bit ack,
                      input bit rsp, input int exp, input bit exp_treq);
      sb_t         e;
      bit          have;
      bit          stray;
      bit          own_c;
      logic [31:0] ea;
      @(posedge clk);
      #1;
      c0.req   = cr;
      c0.cmd   = SCR1_MEM_CMD_RD;
      c0.width = SCR1_MEM_WIDTH_WORD;
      c0.addr  = caddr;
      c0.wdata = caddr ^ 32'h1;
      d0.req   = dr;
      d0.cmd   = dcmd;
      d0.width = SCR1_MEM_WIDTH_WORD;
      d0.addr  = daddr;
      d0.wdata = daddr ^ 32'h2;
      t0.req_ack = ack;
      t0.resp  = SCR1_MEM_RESP_NOTRDY;
      t0.rdata = '0;
      have  = 1'b0;
      stray = 1'b0;
      if (rsp) begin
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            have = 1'b1;
            t0.resp  = e.rsp;
            t0.rdata = e.data;
         end else begin
            stray = 1'b1;
            t0.resp  = SCR1_MEM_RESP_RDY_OK;
            t0.rdata = 32'h1234_5678;
         end
      end
      @(negedge clk);
      check("arb_err", a_err, err_pend);
      err_pend = stray;
      if (have) begin
         own_c = (e.own == SCR1_TCM_ARB_CORE);
         check("core_resp", c_rsp, own_c ? e.rsp : SCR1_MEM_RESP_NOTRDY);
         check("core_rdata", c_rd, own_c ? e.data : 32'h0);
         check("dma_resp", d_rsp, own_c ? SCR1_MEM_RESP_NOTRDY : e.rsp);
         check("dma_rdata", d_rd, own_c ? 32'h0 : e.data);
      end else begin
         check("core_resp_idle", c_rsp, SCR1_MEM_RESP_NOTRDY);
         check("dma_resp_idle", d_rsp, SCR1_MEM_RESP_NOTRDY);
      end
      check("tcm_req", t_req, exp_treq);
      check("core_ack", c_ack, exp == 0);
      check("dma_ack", d_ack, exp == 1);
      if (exp >= 0) begin
         ea = (exp == 0) ? caddr : daddr;
         check("tcm_addr", t_addr, ea);
         check("tcm_cmd", t_cmd, (exp == 0) ? SCR1_MEM_CMD_RD : dcmd);
         e.own  = (exp == 0) ? SCR1_TCM_ARB_CORE : SCR1_TCM_ARB_DMA;
         e.data = tcm_mem(ea);
         e.rsp  = (exp == 1 && dcmd == SCR1_MEM_CMD_WR) ?
                  SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
         sbq.push_back(e);
         if (exp == 0) caddr += 32'h4;
         else          daddr += 32'h4;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      use1 = 1'b0;
      err_pend = 1'b0;
      rst_n = 1'b0;
      caddr = 32'h100;
      daddr = 32'h2000;
      dcmd  = SCR1_MEM_CMD_RD;
      c0.cmd = SCR1_MEM_CMD_RD;
      c0.width = SCR1_MEM_WIDTH_WORD;
      c0.addr = '0;
      c0.wdata = '0;
      d0.cmd = SCR1_MEM_CMD_RD;
      d0.width = SCR1_MEM_WIDTH_WORD;
      d0.addr = '0;
      d0.wdata = '0;
      idle();
      do_reset();

      // core-only read, response one cycle later
      caddr = 32'h100;
      cyc(1, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 1, -1, 0);
      cyc(0, 0, 1, 0, -1, 0);

      // round-robin with both requesting every cycle
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 1, i > 0, i % 2, 1);
      end
      cyc(0, 0, 1, 1, -1, 0);

      // fixed priority instance
      use1 = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 1, i > 0, 0, 1);
      end
      cyc(0, 1, 1, 1, 1, 1);
      cyc(0, 0, 1, 1, -1, 0);
      use1 = 1'b0;

      // queue full stalls, pop frees a slot the same cycle
      do_reset();
      cyc(1, 0, 1, 0, 0, 1);
      cyc(1, 0, 1, 0, 0, 1);
      cyc(1, 0, 1, 0, -1, 0);
      cyc(1, 0, 1, 1, 0, 1);
      cyc(0, 0, 1, 1, -1, 0);
      cyc(0, 0, 1, 1, -1, 0);
      cyc(0, 0, 1, 0, -1, 0);

      // dma write with error response, then queue must be empty
      do_reset();
      dcmd = SCR1_MEM_CMD_WR;
      cyc(0, 1, 1, 0, 1, 1);
      cyc(0, 0, 1, 1, -1, 0);
      cyc(0, 0, 1, 1, -1, 0);
      cyc(0, 0, 1, 0, -1, 0);
      cyc(0, 0, 1, 0, -1, 0);
      dcmd = SCR1_MEM_CMD_RD;

      // reset between accept and response
      do_reset();
      cyc(1, 0, 1, 0, 0, 1);
      do_reset();
      cyc(0, 0, 1, 1, -1, 0);
      cyc(0, 0, 1, 0, -1, 0);
      cyc(0, 0, 1, 0, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
